mdu_seq: RTL
============

Name: mdu_seq

Overview:
- Iterative multiply/divide unit controller for the MIPS core.
- Sequences a 32-iteration shift-add multiplier and restoring divider over a shared 64-bit accumulator, and owns the architectural HI/LO registers.
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO, with a start/busy/done handshake to the pipeline stall logic.
- MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- WIDTH, 32, operand width; only 32 is supported, and iteration count = WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  launch operation `op` with `rs_val`/`rt_val`; sampled only in IDLE
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- mthi  in  1  write `wdata` to HI
- mtlo  in  1  write `wdata` to LO
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress; the core stalls MD instructions while it is high
- done  out  1  one-cycle pulse: HI/LO were just updated by an operation
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, accumulator=0.
  - Reset mid-operation aborts immediately; HI/LO are cleared, not partially written.
- FSM states: IDLE, RUN, FIX.
  - IDLE, start=1 at edge E0:
    - latch op;
    - latch operand magnitudes (signed ops take absolute values; unsigned ops pass through);
    - latch result signs (product sign = rs[31]^rt[31]; quotient sign = rs[31]^rt[31]; remainder sign = rs[31]);
    - latch a divide-by-zero flag (rt_val==0 and op is DIV/DIVU);
    - cnt=0; go to RUN; busy=1.
  - RUN: one iteration per edge. cnt increments; after the edge with cnt==31, go to FIX. There are exactly 32 RUN edges (E1..E32).
    - Multiply: if multiplier LSB=1, add multiplicand into the upper half of the 64-bit accumulator with carry; shift the accumulator right by 1.
    - Divide (restoring): shift {remainder, quotient} left by 1; trial-subtract the divisor from the remainder; if no borrow, keep the difference and set quotient LSB=1.
  - FIX (edge E33):
    - apply sign correction (two's-complement negate where the latched sign is 1 for signed ops);
    - write HI/LO;
    - go to IDLE; busy=0; done=1 for exactly one cycle (the cycle after E33).
- Latency: busy is high for 33 cycles after the start edge; results are visible on hi/lo in the same cycle done is high.
- Results:
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient, HI = remainder.
  - Signed remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): HI=rs_val (raw), LO=32'hFFFF_FFFF. Still takes full latency.
- DIV 0x8000_0000 / -1: LO=0x8000_0000, HI=0. This falls out of the magnitude path and needs no special case.
- start while busy (RUN/FIX): ignored, no queuing.
- mthi/mtlo: honoured only in IDLE with start=0; update HI/LO at the next edge with no busy assertion and no done pulse.
  - mthi and mtlo together in IDLE: both registers take `wdata`.
  - start together with mthi/mtlo in IDLE: start wins; the writes are dropped.
  - mthi/mtlo while busy: ignored.
- Operand inputs need only be valid in the start cycle; later changes have no effect.
- HI/LO hold their values at all times except the FIX edge, an accepted MTHI/MTLO, and reset.

Decomposition:
- Shared package `mdu_pkg`:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - state encodings S_IDLE/S_RUN/S_FIX;
  - constant MD_ITER=32.
- One sub-module `mdu_step`: a combinational single-iteration datapath. It takes accumulator, operand and op class, and returns the next accumulator (add-shift or shift-subtract-restore).
- The FSM, counter, sign/zero flags, sign fix and HI/LO registers stay in `mdu_seq`.

Test Plan:
- MULTU rs=0xFFFF_FFFF, rt=0xFFFF_FFFF, start at E0 -> busy=1 over E1..E33; done=1 in the cycle after E33; HI=0xFFFF_FFFE, LO=0x0000_0001.
- MULT rs=-3 (0xFFFF_FFFD), rt=7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. DIVU rs=288, rt=31 -> LO=9, HI=9.
- DIV rs=-7, rt=2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIV rs=0x8000_0000, rt=0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- DIVU rs=0x1234_5678, rt=0 -> after 33 busy cycles: HI=0x1234_5678, LO=0xFFFF_FFFF, done pulses once.
- In IDLE: mthi with wdata=0xA5A5_A5A5 -> HI=0xA5A5_A5A5 next cycle, busy/done stay 0. Then start MULTU 2×3 and pulse mthi (wdata=0xDEAD_BEEF) plus a second start at E5 -> both ignored; final HI=0, LO=6.
- Start DIVU 100/7, then drop rst_n low at E10 -> busy=0, done=0, HI=LO=0 immediately. After release, a new MULTU 5×5 gives LO=25 with full 33-cycle latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  // Number of datapath iterations per operation (one per operand bit).
  localparam int MD_ITER = 32;

  // Operation encodings as presented on the op port.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared multiply/divide datapath.
// Multiply: accumulator = {partial product, remaining multiplier bits}.
// Divide:   accumulator = {partial remainder, dividend/quotient bits}.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Add-shift for multiply, shift-subtract-restore for divide.
  always_comb begin
    // Carry out of the upper-half add becomes the new MSB after the shift.
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Remainder after the left shift can need one extra bit before the trial subtract.
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    fits    = (rem_sh >= {1'b0, operand});
    // Only used when it fits, so the result is below the divisor and fits WIDTH bits.
    diff    = rem_sh[WIDTH-1:0] - operand;
    if (is_div) begin
      if (fits) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer owning the HI/LO registers.
//
// Handshake: start is sampled only while idle (busy=0). The edge that accepts
// start raises busy for the next 33 cycles; HI/LO are written on the last of
// those edges and done is high for exactly the one cycle that follows, during
// which hi/lo already show the result. start, mthi and mtlo are ignored while
// busy; nothing is queued.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MD_ITER);

  md_state_e          state;
  md_state_e          state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   rs_raw;
  logic               is_div_q;
  logic               is_signed_q;
  logic               res_sign;
  logic               rem_sign;
  logic               div_zero;

  logic               op_div;
  logic               op_signed;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] result;

  // Decode the requested operation and form operand magnitudes for the start cycle.
  always_comb begin
    op_div    = (op == MD_DIV) || (op == MD_DIVU);
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    rs_mag    = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_mag    = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  end

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .operand (operand),
    .is_div  (is_div_q),
    .acc_next(acc_next)
  );

  // Sign correction and final HI/LO selection, consumed on the FIX edge.
  // The most-negative dividend over -1 needs nothing special: its magnitude
  // quotient 0x8000_0000 negates back to itself.
  always_comb begin
    prod_fix = (is_signed_q && res_sign) ? -acc : acc;
    quo_fix  = (is_signed_q && res_sign) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = (is_signed_q && rem_sign) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (div_zero) begin
      result = {rs_raw, {WIDTH{1'b1}}};
    end else if (is_div_q) begin
      result = {rem_fix, quo_fix};
    end else begin
      result = prod_fix;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and busy decode.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(MD_ITER - 1)) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture at start and one datapath iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      operand     <= '0;
      rs_raw      <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      res_sign    <= 1'b0;
      rem_sign    <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div_q    <= op_div;
            is_signed_q <= op_signed;
            res_sign    <= rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
            rem_sign    <= rs_val[WIDTH-1];
            div_zero    <= op_div && (rt_val == '0);
            rs_raw      <= rs_val;
            cnt         <= '0;
            acc         <= {{WIDTH{1'b0}}, (op_div ? rs_mag : rt_mag)};
            operand     <= op_div ? rt_mag : rs_mag;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO registers: written by a finished operation or an idle MTHI/MTLO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_FIX) begin
        hi   <= result[2*WIDTH-1:WIDTH];
        lo   <= result[WIDTH-1:0];
        done <= 1'b1;
      end else if ((state == S_IDLE) && !start) begin
        if (mthi) begin
          hi <= wdata;
        end
        if (mtlo) begin
          lo <= wdata;
        end
      end
    end
  end

endmodule
